// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer: post-add normalize, round-to-nearest-even and pack stage
// for a single-precision adder. Fixed 3-cycle latency, accepts one result per cycle.
module fp_add_normalizer #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mant,
    input  logic [1:0]  in_class,
    output logic        out_vld,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);

    localparam logic [1:0] CLS_OK  = 2'b00;
    localparam logic [1:0] CLS_NAN = 2'b01;
    localparam logic [1:0] CLS_INF = 2'b10;
    localparam logic [1:0] CLS_NUL = 2'b11;

    // Leading-zero count of the 27-bit hidden+fraction+GRS field.
    function automatic logic [4:0] lzc27(input logic [26:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even on the 24-bit significand m[26:3]; bit 24 is carry-out.
    function automatic logic [24:0] round_rne(input logic [26:0] m);
        logic inc;
        inc = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[26:3]} + {24'd0, inc};
    endfunction

    // Round, renormalize on carry, then saturate/flush: returns {ovf, unf, inexact, result}.
    function automatic logic [34:0] pack_result(input logic sign,
                                                input logic signed [9:0] exp,
                                                input logic [26:0] m);
        logic [24:0]       sum;
        logic signed [9:0] e;
        logic [22:0]       frac;
        logic              inx;
        sum  = round_rne(m);
        e    = exp + $signed({9'd0, sum[24]});
        frac = sum[24] ? sum[23:1] : sum[22:0];
        inx  = |m[2:0];
        if (e >= 10'sd255)
            return {1'b1, 1'b0, 1'b1, sign, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            return {1'b0, 1'b1, 1'b1, sign, 31'h0};
        else
            return {1'b0, 1'b0, inx, sign, e[7:0], frac};
    endfunction

    logic              vld_p0, vld_p1;
    logic              sign_p0, sign_p1;
    logic [1:0]        class_p0, class_p1;
    logic              zero_p0, zero_p1;
    logic signed [9:0] exp_p0, exp_p1;
    logic [26:0]       mant_p0, mant_p1;
    logic [4:0]        lzc_p0;

    logic [31:0]       res_c;
    logic              ovf_c, unf_c, inx_c;

    // Valid pipeline: advances every cycle, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= in_vld;
            vld_p1 <= vld_p0;
        end
    end

    // Stage 1: absorb carry by a right shift with sticky, or find the leading-zero count.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            sign_p0  <= in_sign;
            class_p0 <= in_class;
            zero_p0  <= (in_mant == 28'd0);
            if (in_mant[27]) begin
                mant_p0 <= {in_mant[27:2], in_mant[1] | in_mant[0]};
                exp_p0  <= $signed({2'b00, in_exp}) + 10'sd1;
                lzc_p0  <= 5'd0;
            end else begin
                mant_p0 <= in_mant[26:0];
                exp_p0  <= $signed({2'b00, in_exp});
                lzc_p0  <= lzc27(in_mant[26:0]);
            end
        end
    end

    // Stage 2: left-normalize and adjust the exponent (may go non-positive).
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            sign_p1  <= sign_p0;
            class_p1 <= class_p0;
            zero_p1  <= zero_p0;
            mant_p1  <= mant_p0 << lzc_p0;
            exp_p1   <= exp_p0 - $signed({5'd0, lzc_p0});
        end
    end

    // Stage 3 logic: special classes override, exact cancellation gives +0.
    always_comb begin
        res_c = 32'h0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        inx_c = 1'b0;
        case (class_p1)
            CLS_NAN: res_c = QNAN;
            CLS_INF: res_c = {sign_p1, 8'hFF, 23'h0};
            CLS_NUL: res_c = {sign_p1, 31'h0};
            CLS_OK: begin
                if (!zero_p1)
                    {ovf_c, unf_c, inx_c, res_c} = pack_result(sign_p1, exp_p1, mant_p1);
            end
            default: res_c = 32'h0;
        endcase
    end

    // Stage 3 register: result holds between valids, flags are forced low when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld     <= 1'b0;
            out_result  <= 32'h0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            out_vld     <= vld_p1;
            out_ovf     <= vld_p1 & ovf_c;
            out_unf     <= vld_p1 & unf_c;
            out_inexact <= vld_p1 & inx_c;
            if (vld_p1) out_result <= res_c;
        end
    end

endmodule
